// File: rtl/fp32_tb_pkg.sv
// fp32_tb_pkg
// Shared definitions for the fp32 adder result checker: fp32 field
// positions, the checker state encoding, the FIFO entry layout and two
// small helpers (NaN detection and saturating increment).
package fp32_tb_pkg;

  // fp32 field boundaries
  localparam int         EXP_MSB = 30;
  localparam int         EXP_LSB = 23;
  localparam int         MAN_MSB = 22;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  // Checker phases: accepting stimulus, waiting for outstanding results,
  // finished (terminal until reset).
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One issued operation: operands plus the golden sum (96 bits).
  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] ref_sum;
  } chk_entry_t;

  // Any NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_MAX) && (v[MAN_MSB:0] != '0);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// chk_fifo
// Synchronous FIFO holding issued operations until their result arrives.
// The head entry is visible combinationally (first-word fall-through), so
// the compare can happen in the same cycle as the pop.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-low reset (pointers and count only)
//   push   : write data this cycle (caller guarantees room, or a same-cycle pop)
//   pop    : retire the head entry this cycle (caller guarantees non-empty)
//   data   : entry to write
//   head   : oldest entry, valid whenever empty is low
//   full   : DEPTH entries stored
//   empty  : no entries stored
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module chk_fifo
  import fp32_tb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  chk_entry_t data,
  output chk_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  chk_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  // NOTE: the storage array has no reset on purpose; only pointers and
  // count define which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fp32_add_checker.sv
// fp32_add_checker
// Scoreboard for an fp32 adder under test. Each stimulus beat queues the
// operands and the golden sum; each adder result, arriving in issue order
// with arbitrary latency, is compared against the oldest queued entry.
// Bit-exact results pass, and any NaN matches any other NaN.
//
// Ports
//   clk, rst              : clock and synchronous active-low reset
//   in_val, x1, x2        : operand pair issued to the adder
//   ref_sum               : golden sum, valid with in_val
//   over                  : the current in_val beat is the last one
//   dut_val, dut_sum      : adder result stream
//   pass_cnt, err_cnt     : saturating match / mismatch counters
//   mismatch              : one-cycle pulse per failed compare
//   mis_x1/x2/exp/got     : context of the most recent mismatch
//   overflow, underflow   : sticky queue misuse flags
//   timeout               : sticky, drain ended because results stopped
//   done                  : checking finished, held until reset
module fp32_add_checker
  import fp32_tb_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] ref_sum,
  input  logic        over,
  input  logic        dut_val,
  input  logic [31:0] dut_sum,
  output logic [31:0] pass_cnt,
  output logic [31:0] err_cnt,
  output logic        mismatch,
  output logic [31:0] mis_x1,
  output logic [31:0] mis_x2,
  output logic [31:0] mis_exp,
  output logic [31:0] mis_got,
  output logic        overflow,
  output logic        underflow,
  output logic        timeout,
  output logic        done
);

  localparam int IW = $clog2(TIMEOUT + 1);

  state_t     state;
  logic [IW-1:0] idle_cnt;

  chk_entry_t wr_entry;
  chk_entry_t head;
  logic       full;
  logic       empty;

  logic       push_req;
  logic       pop_req;
  logic       do_push;
  logic       do_pop;
  logic       equal;

  // Stimulus is only accepted while running; results are ignored once done.
  assign push_req = in_val && (state == RUN);
  assign pop_req  = dut_val && (state != DONE);

  // A result against an empty queue is never matched, even when a push
  // lands in the same cycle; that entry stays queued for the next result.
  assign do_pop   = pop_req && !empty;
  // Pushing into a full queue is legal only when the head leaves this cycle.
  assign do_push  = push_req && (!full || do_pop);

  assign wr_entry = '{x1: x1, x2: x2, ref_sum: ref_sum};

  assign equal = (head.ref_sum == dut_sum) ||
                 (is_nan(head.ref_sum) && is_nan(dut_sum));

  chk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .data  (wr_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      idle_cnt  <= '0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      mismatch  <= 1'b0;
      mis_x1    <= '0;
      mis_x2    <= '0;
      mis_exp   <= '0;
      mis_got   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Compare outcome is registered at the edge that retires the entry.
      mismatch <= 1'b0;
      if (do_pop) begin
        if (equal) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          err_cnt  <= sat_inc(err_cnt);
          mismatch <= 1'b1;
          mis_x1   <= head.x1;
          mis_x2   <= head.x2;
          mis_exp  <= head.ref_sum;
          mis_got  <= dut_sum;
        end
      end

      if (push_req && full && !do_pop) overflow  <= 1'b1;
      if (pop_req && empty)            underflow <= 1'b1;

      case (state)
        RUN: begin
          idle_cnt <= '0;
          // The beat carrying over is still pushed above.
          if (in_val && over) state <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (dut_val) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th silent one after the last result.
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_checker.sv
// tb_fp32_add_checker
// Directed bench for fp32_add_checker: single compares (match, mismatch,
// NaN equivalence), queue overflow/underflow, push+pop while full, reset
// mid-operation, drain completion and drain timeout.
module tb_fp32_add_checker;
  import fp32_tb_pkg::*;

  localparam int DEPTH = 16;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] ref_sum;
  logic        over;
  logic        dut_val;
  logic [31:0] dut_sum;
  logic [31:0] pass_cnt;
  logic [31:0] err_cnt;
  logic        mismatch;
  logic [31:0] mis_x1;
  logic [31:0] mis_x2;
  logic [31:0] mis_exp;
  logic [31:0] mis_got;
  logic        overflow;
  logic        underflow;
  logic        timeout;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  fp32_add_checker #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .x1        (x1),
    .x2        (x2),
    .ref_sum   (ref_sum),
    .over      (over),
    .dut_val   (dut_val),
    .dut_sum   (dut_sum),
    .pass_cnt  (pass_cnt),
    .err_cnt   (err_cnt),
    .mismatch  (mismatch),
    .mis_x1    (mis_x1),
    .mis_x2    (mis_x2),
    .mis_exp   (mis_exp),
    .mis_got   (mis_got),
    .overflow  (overflow),
    .underflow (underflow),
    .timeout   (timeout),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic last);
    in_val = 1'b1; x1 = a; x2 = b; ref_sum = r; over = last;
    tick();
    in_val = 1'b0; over = 1'b0;
  endtask

  task automatic result(input logic [31:0] s);
    dut_val = 1'b1; dut_sum = s;
    tick();
    dut_val = 1'b0;
  endtask

  task automatic push_and_result(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] r, input logic [31:0] s);
    in_val = 1'b1; x1 = a; x2 = b; ref_sum = r; over = 1'b0;
    dut_val = 1'b1; dut_sum = s;
    tick();
    in_val = 1'b0; dut_val = 1'b0;
  endtask

  task automatic check_all_clear(input string pfx);
    check({pfx, "_pass"},  pass_cnt, 32'd0);
    check({pfx, "_err"},   err_cnt, 32'd0);
    check({pfx, "_mis"},   32'(mismatch), 32'd0);
    check({pfx, "_mx1"},   mis_x1, 32'd0);
    check({pfx, "_mx2"},   mis_x2, 32'd0);
    check({pfx, "_mexp"},  mis_exp, 32'd0);
    check({pfx, "_mgot"},  mis_got, 32'd0);
    check({pfx, "_ovf"},   32'(overflow), 32'd0);
    check({pfx, "_udf"},   32'(underflow), 32'd0);
    check({pfx, "_tmo"},   32'(timeout), 32'd0);
    check({pfx, "_done"},  32'(done), 32'd0);
    check({pfx, "_state"}, 32'(dut.state), 32'(RUN));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_val = 1'b0; over = 1'b0; dut_val = 1'b0;
    x1 = '0; x2 = '0; ref_sum = '0; dut_sum = '0;
    tick();
    tick();
    rst = 1'b1;
    check_all_clear("por");

    // 1.0 + 1.0 = 2.0, result three cycles after issue
    push(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    tick();
    tick();
    check("add_pre_pass", pass_cnt, 32'd0);
    result(32'h4000_0000);
    check("add_pass", pass_cnt, 32'd1);
    check("add_err",  err_cnt, 32'd0);
    check("add_mis",  32'(mismatch), 32'd0);

    // Off by one ulp
    push(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    result(32'h4000_0001);
    check("ulp_mis",  32'(mismatch), 32'd1);
    check("ulp_err",  err_cnt, 32'd1);
    check("ulp_pass", pass_cnt, 32'd1);
    check("ulp_mexp", mis_exp, 32'h4000_0000);
    check("ulp_mgot", mis_got, 32'h4000_0001);
    check("ulp_mx1",  mis_x1, 32'h3F80_0000);
    tick();
    check("ulp_pulse", 32'(mismatch), 32'd0);

    // NaN vs NaN with different sign and payload
    push(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
    result(32'hFFC0_0001);
    check("nan_pass", pass_cnt, 32'd2);
    check("nan_mis",  32'(mismatch), 32'd0);

    // NaN expected, infinity returned: not equal
    push(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
    result(32'h7F80_0000);
    check("inf_mis",  32'(mismatch), 32'd1);
    check("inf_err",  err_cnt, 32'd2);
    check("inf_mx2",  mis_x2, 32'hFF80_0000);
    check("inf_mgot", mis_got, 32'h7F80_0000);

    // 17 pushes into a 16-deep queue, then 16 results and one extra
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) begin
      push(32'(k), 32'(k + 100), 32'h4000_0000 + 32'(k), 1'b0);
      if (k == DEPTH - 1) check("ovf_16", 32'(overflow), 32'd0);
    end
    check("ovf_17", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) result(32'h4000_0000 + 32'(k));
    check("drain16_pass", pass_cnt, 32'd16);
    check("drain16_err",  err_cnt, 32'd0);
    check("drain16_udf",  32'(underflow), 32'd0);
    result(32'h4000_0000);
    check("extra_udf",  32'(underflow), 32'd1);
    check("extra_pass", pass_cnt, 32'd16);
    check("extra_err",  err_cnt, 32'd0);

    // Push and pop together while full; pointers wrap
    do_reset();
    check("full_rst_pass", pass_cnt, 32'd0);
    for (int k = 0; k < DEPTH; k++)
      push(32'(k), 32'(k), 32'h3000_0000 + 32'(k), 1'b0);
    push_and_result(32'(16), 32'(16), 32'h3000_0010, 32'h3000_0000);
    check("pp_full_ovf",  32'(overflow), 32'd0);
    check("pp_full_pass", pass_cnt, 32'd1);
    for (int k = 1; k <= DEPTH; k++) result(32'h3000_0000 + 32'(k));
    check("wrap_pass", pass_cnt, 32'd17);
    check("wrap_err",  err_cnt, 32'd0);
    check("wrap_udf",  32'(underflow), 32'd0);
    // Result against empty queue with a same-cycle push: no forwarding
    push_and_result(32'd20, 32'd20, 32'h3000_0014, 32'h3000_0014);
    check("fwd_udf",  32'(underflow), 32'd1);
    check("fwd_pass", pass_cnt, 32'd17);
    result(32'h3000_0014);
    check("fwd_next_pass", pass_cnt, 32'd18);
    check("fwd_next_err",  err_cnt, 32'd0);

    // Reset with entries pending and mismatch context populated
    do_reset();
    for (int k = 0; k < 6; k++)
      push(32'(k), 32'(k), 32'h5000_0000 + 32'(k), 1'b0);
    result(32'h0000_0000);
    check("pre_rst_err",  err_cnt, 32'd1);
    check("pre_rst_mexp", mis_exp, 32'h5000_0000);
    do_reset();
    check_all_clear("mid_rst");
    result(32'h5000_0001);
    check("post_rst_udf",  32'(underflow), 32'd1);
    check("post_rst_pass", pass_cnt, 32'd0);
    check("post_rst_err",  err_cnt, 32'd0);

    // Drain timeout: two pending, one result, then silence
    do_reset();
    push(32'd1, 32'd1, 32'h6000_0001, 1'b0);
    push(32'd2, 32'd2, 32'h6000_0002, 1'b1);
    check("drain_state", 32'(dut.state), 32'(DRAIN));
    tick();
    tick();
    tick();
    result(32'h6000_0001);
    check("tmo_pass", pass_cnt, 32'd1);
    repeat (TO - 1) tick();
    check("tmo_early_done", 32'(done), 32'd0);
    check("tmo_early_flag", 32'(timeout), 32'd0);
    tick();
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_flag", 32'(timeout), 32'd1);
    result(32'h0000_0000);
    check("done_udf",  32'(underflow), 32'd0);
    check("done_pass", pass_cnt, 32'd1);
    check("done_err",  err_cnt, 32'd0);
    check("done_hold", 32'(done), 32'd1);

    // Normal drain completion; a beat after over is not queued
    do_reset();
    push(32'd3, 32'd3, 32'h7000_0003, 1'b1);
    push(32'd4, 32'd4, 32'h7000_0004, 1'b0);
    result(32'h7000_0003);
    check("fin_pass", pass_cnt, 32'd1);
    for (int i = 0; i < 8 && !done; i++) tick();
    check("fin_done", 32'(done), 32'd1);
    check("fin_tmo",  32'(timeout), 32'd0);
    check("fin_udf",  32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_add_checker.md
FP32_ADD_CHECKER -- requirements
Module: fp32_add_checker

Interface
REQ-001 SHALL have parameter DEPTH, 16, operand/expected FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT, 64, drain cycles without dut_val before forced completion.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_val  input  1  operand pair valid from stimulus source.
REQ-006 SHALL have ports x1, x2  input  32 each  fp32 operands issued to the adder.
REQ-007 SHALL have port ref_sum  input  32  golden fp32 sum of x1+x2, valid with in_val.
REQ-008 SHALL have port over  input  1  stimulus exhausted; current in_val beat is the last one.
REQ-009 SHALL have ports dut_val (input, 1) and dut_sum (input, 32)  adder result, in issue order, arbitrary latency.
REQ-010 SHALL have ports pass_cnt and err_cnt  output  32 each  saturating match/mismatch counters.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse per failed compare.
REQ-012 SHALL have ports mis_x1, mis_x2, mis_exp, mis_got  output  32 each  operands, expected and DUT value of the latest mismatch.
REQ-013 SHALL have ports overflow, underflow, timeout  output  1 each  sticky error flags.
REQ-014 SHALL have port done  output  1  checking complete; held until reset.

Function
REQ-015 SHALL push {x1,x2,ref_sum} into the FIFO on each cycle with in_val=1 while state is RUN.
REQ-016 SHALL pop the head entry and compare on each cycle with dut_val=1 and FIFO non-empty.
REQ-017 SHALL treat results as equal if the 32 bits match, or if both are NaN (exp=8'hFF, mantissa!=0) regardless of sign/payload.
REQ-018 SHALL register compare outcome: pass_cnt/err_cnt, mismatch and mis_* update exactly 1 cycle after the dut_val beat.
REQ-019 SHALL allow simultaneous push and pop in one cycle, including when full (count unchanged, no overflow).
REQ-020 SHALL, on push when full without pop, drop the entry and set overflow.
REQ-021 SHALL, on dut_val with FIFO empty and no same-cycle push, set underflow and perform no compare; with a same-cycle push into an empty FIFO, set underflow and not forward the entry.
REQ-022 SHALL saturate counters at 32'hFFFF_FFFF; FIFO pointers wrap modulo DEPTH.
REQ-023 SHALL implement states RUN, DRAIN, DONE; RUN->DRAIN on in_val&over (that beat is pushed); pushes ignored outside RUN.
REQ-024 SHALL go DRAIN->DONE when FIFO empty and no compare pending, or after TIMEOUT consecutive cycles without dut_val (then set timeout); DONE is terminal.
REQ-025 SHALL ignore dut_val in DONE (no counting, no underflow).

Reset
REQ-026 SHALL, while rst=0 at posedge clk, clear FIFO pointers/count, counters, mis_*, mismatch, flags and done, and enter RUN.
REQ-027 SHALL discard all pending entries and in-flight compares on reset asserted mid-operation; first post-reset dut_val without push sets underflow.

Structure
REQ-028 SHALL take the FP32 field constants (EXP_MSB=30, EXP_LSB=23, MAN_MSB=22, EXP_MAX=8'hFF) and the state enum from shared package fp32_tb_pkg.
REQ-029 SHALL instantiate one sub-module, chk_fifo (synchronous, DEPTH x 96 bits, full/empty, first-word-fall-through head).

Verification
REQ-030 SHALL cover: push x1=x2=32'h3F80_0000, ref=32'h4000_0000, dut_sum=32'h4000_0000 3 cycles later -> pass_cnt=1, err_cnt=0, no mismatch.
REQ-031 SHALL cover: same push, dut_sum=32'h4000_0001 -> mismatch pulse 1 cycle later, mis_exp=32'h4000_0000, mis_got=32'h4000_0001, err_cnt=1.
REQ-032 SHALL cover: ref=32'h7FC0_0000, dut_sum=32'hFFC0_0001 -> pass_cnt increments, no mismatch.
REQ-033 SHALL cover: 17 consecutive pushes, no dut_val -> overflow=1 on 17th; then 16 results -> 16 compares, then extra dut_val -> underflow=1.
REQ-034 SHALL cover: over with 2 entries pending, 1 result, then silence -> done and timeout=1 exactly TIMEOUT cycles after the last dut_val.
REQ-035 SHALL cover: rst=0 for 1 cycle with 5 entries pending -> all outputs zero, state RUN, next dut_val sets underflow.
